hazard_detection: RTL and testbench
===================================

Name: hazard_detection

Overview:
- RAW data-hazard detection and pipeline control for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding paths.
- Compares the source registers of the instruction in ID against the destination registers of the valid instructions in EX, MEM and WB.
- Drives the PC and pipeline-register enable and flush controls.
- Sits beside the datapath and observes the instruction word held in each stage register.

Parameters:
- XLEN, 32, instruction width (fixed at 32).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- instr_D  input  32  instruction in the IF/ID register
- instr_E  input  32  instruction in the ID/EX register
- instr_M  input  32  instruction in the EX/MEM register
- instr_W  input  32  instruction in the MEM/WB register
- pc_enable  output  1  PC update enable
- IF_ID_enable  output  1  IF/ID register load enable
- ID_EX_enable  output  1  ID/EX register load enable
- ID_EX_flush  output  1  load a bubble (NOP) into ID/EX
- EX_ME_enable  output  1  EX/MEM register load enable
- EX_ME_flush  output  1  load a bubble into EX/MEM
- ME_WB_enable  output  1  MEM/WB register load enable
- ME_WB_flush  output  1  load a bubble into MEM/WB

Behaviour:

Decode (combinational, applied per stage):
- reads_rs1 for opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1100111 (JALR).
- reads_rs2 for opcodes R, store, branch.
- writes_rd for opcodes R, I-ALU, load, JAL 1101111, JALR, LUI 0110111, AUIPC 0010111, and only when rd != x0.
- Any other opcode (including all-zero) reads and writes nothing.
- Field positions: rs1 = [19:15], rs2 = [24:20], rd = [11:7].

Valid tracking (sequential):
- Registers valid_D, valid_E, valid_M, valid_W; all cleared asynchronously while rst=1.
- Per rising edge:
  - valid_D <= 1 when IF_ID_enable, else unchanged.
  - valid_E <= valid_D & ~ID_EX_flush.
  - valid_M <= valid_E.
  - valid_W <= valid_M.
- A stage that is not valid never produces or suffers a hazard.

Hazard condition:
- hazard = valid_D & OR over stage X in {E, M, W} of (valid_X & writes_rd_X & ((reads_rs1_D & rs1_D == rd_X) | (reads_rs2_D & rs2_D == rd_X))).
- WB is included because the register file has no write-through bypass; the write takes effect at the end of the WB cycle.

Outputs (combinational from inputs and valid registers, zero latency):
- rst=1: all enables 0, all flushes 1.
- Normal operation, no hazard: all enables 1, all flushes 0.
- Hazard:
  - pc_enable=0, IF_ID_enable=0 (freeze IF and ID).
  - ID_EX_enable=1, ID_EX_flush=1 (insert bubble).
  - EX_ME and ME_WB enabled and not flushed (older instructions drain).
- A stall persists until the producer leaves WB: 3 bubbles when the producer is adjacent, 2 when one instruction apart, 1 when two apart.
- Matches against multiple producers simultaneously: stall continues until the last matching producer has retired.
- Reset asserted mid-stall: outputs go to the reset values immediately and the valid bits clear. The first instruction after reset release sees no hazard.

Decomposition:
- Package hazard_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC) and a typedef struct reg_use_t {rs1, rs2, rd, reads_rs1, reads_rs2, writes_rd}.
- One sub-module, instr_reg_use: pure combinational decode of a 32-bit instruction into reg_use_t. Instantiated four times (D, E, M, W).

Test Plan:
1. Reset: hold rst=1 with arbitrary instructions -> pc_enable=0, all enables 0, all flushes 1. Release -> all enables 1, flushes 0.
2. Adjacent RAW: fetch 0x002182B3 (add x5,x3,x2), then 0x0012C333 (xor x6,x5,x1).
   - Stall while add is in E, M, W: 3 cycles with pc_enable=0, IF_ID_enable=0, ID_EX_flush=1.
   - Then xor advances and controls return to normal.
3. Distance-2 RAW: add x5,x3,x2; NOP 0x00000013; sub x9,x3,x5 (0x405184B3) -> exactly 2 stall cycles.
4. rs2 match and x0 exclusion:
   - or x2,x7,x5 (0x0053E133) after add x5 -> stall.
   - add x0,x3,x2 followed by a reader of x0 -> no stall.
5. Non-reader/non-writer cases:
   - LUI in D following add x5 -> no stall.
   - Store 0x00502023 (sw x5,0(x0)) after add x5 -> stall (rs2 read).
   - Branch in E as producer -> never causes a stall.
6. Reset during stall: assert rst in cycle 2 of the stall in scenario 2 -> reset outputs immediately. After release, with instr_D=xor and instr_E=add still present, no hazard until the valid bits refill.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the RV32I RAW hazard detection unit.
//   - Opcode constants for the instruction classes the decoder cares about.
//   - reg_use_t: which architectural registers an instruction reads/writes.
//   - raw_match(): true when a consumer reads a register a producer writes.
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reads_rs1;
      logic       reads_rs2;
      logic       writes_rd;
   } reg_use_t;

   // writes_rd is already cleared for rd == x0 by the decoder, so a match
   // here always means a real pending register-file write.
   function automatic logic raw_match(input reg_use_t consumer,
                                      input reg_use_t producer);
      logic hit1;
      logic hit2;
      hit1 = consumer.reads_rs1 && (consumer.rs1 == producer.rd);
      hit2 = consumer.reads_rs2 && (consumer.rs2 == producer.rd);
      return producer.writes_rd && (hit1 || hit2);
   endfunction

endpackage

// File: rtl/instr_reg_use.sv
// -----------------------------------------------------------------------------
// instr_reg_use
// Pure combinational decode of one RV32I instruction word into its register
// usage (source/destination fields and whether each is actually used).
// Ports:
//   instr    input  XLEN-bit instruction word
//   reg_use  output reg_use_t decoded register usage
// -----------------------------------------------------------------------------
module instr_reg_use
   import hazard_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr,
   output reg_use_t        reg_use
);

   // funct3/funct7 never influence register usage for the classes decoded here
   logic unused_funct;
   assign unused_funct = ^{instr[XLEN-1:25], instr[14:12]};

   // Field extraction is unconditional; the opcode only decides which
   // fields are meaningful. Unknown opcodes (including all-zero) use nothing.
   always_comb begin
      reg_use           = '0;
      reg_use.rs1       = instr[19:15];
      reg_use.rs2       = instr[24:20];
      reg_use.rd        = instr[11:7];
      case (instr[6:0])
         OP_R: begin
            reg_use.reads_rs1 = 1'b1;
            reg_use.reads_rs2 = 1'b1;
            reg_use.writes_rd = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            reg_use.reads_rs1 = 1'b1;
            reg_use.writes_rd = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            reg_use.reads_rs1 = 1'b1;
            reg_use.reads_rs2 = 1'b1;
         end
         OP_JAL, OP_LUI, OP_AUIPC: begin
            reg_use.writes_rd = 1'b1;
         end
         default: begin
            reg_use.reads_rs1 = 1'b0;
         end
      endcase
      // x0 is hardwired, so writing it never creates a dependency
      if (instr[11:7] == 5'd0) begin
         reg_use.writes_rd = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_detection.sv
// -----------------------------------------------------------------------------
// hazard_detection
// RAW hazard detection and stall control for a 5-stage RV32I pipeline with no
// forwarding. The ID instruction is compared against valid producers in EX,
// MEM and WB; on a match IF/ID freeze and a bubble is pushed into ID/EX while
// older instructions keep draining.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   instr_D/E/M/W            instruction words held in IF/ID, ID/EX, EX/MEM,
//                            MEM/WB
//   pc_enable, IF_ID_enable  fetch-side enables (low during a stall)
//   ID_EX_enable/flush       ID/EX load enable / bubble insert
//   EX_ME_enable/flush       EX/MEM load enable / bubble insert
//   ME_WB_enable/flush       MEM/WB load enable / bubble insert
// -----------------------------------------------------------------------------
module hazard_detection
   import hazard_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] instr_D,
   input  logic [XLEN-1:0] instr_E,
   input  logic [XLEN-1:0] instr_M,
   input  logic [XLEN-1:0] instr_W,
   output logic            pc_enable,
   output logic            IF_ID_enable,
   output logic            ID_EX_enable,
   output logic            ID_EX_flush,
   output logic            EX_ME_enable,
   output logic            EX_ME_flush,
   output logic            ME_WB_enable,
   output logic            ME_WB_flush
);

   reg_use_t use_D;
   reg_use_t use_E;
   reg_use_t use_M;
   reg_use_t use_W;

   logic valid_D;
   logic valid_E;
   logic valid_M;
   logic valid_W;
   logic hazard;

   instr_reg_use #(.XLEN(XLEN)) u_dec_D (.instr(instr_D), .reg_use(use_D));
   instr_reg_use #(.XLEN(XLEN)) u_dec_E (.instr(instr_E), .reg_use(use_E));
   instr_reg_use #(.XLEN(XLEN)) u_dec_M (.instr(instr_M), .reg_use(use_M));
   instr_reg_use #(.XLEN(XLEN)) u_dec_W (.instr(instr_W), .reg_use(use_W));

   // ID is only ever a consumer and EX/MEM/WB only producers here
   logic unused_fields;
   assign unused_fields = ^{use_D.rd, use_D.writes_rd,
                            use_E.rs1, use_E.rs2, use_E.reads_rs1, use_E.reads_rs2,
                            use_M.rs1, use_M.rs2, use_M.reads_rs1, use_M.reads_rs2,
                            use_W.rs1, use_W.rs2, use_W.reads_rs1, use_W.reads_rs2};

   // Valid bits shadow the stage registers so that stale words left behind by
   // reset or bubbles never look like real producers or consumers. IF/ID
   // becomes valid on its first load after reset; bubbles enter at ID/EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_D <= 1'b0;
         valid_E <= 1'b0;
         valid_M <= 1'b0;
         valid_W <= 1'b0;
      end else begin
         if (IF_ID_enable) begin
            valid_D <= 1'b1;
         end
         valid_E <= valid_D & ~ID_EX_flush;
         valid_M <= valid_E;
         valid_W <= valid_M;
      end
   end

   // WB counts as a producer because the register file has no write-through
   // bypass: the value only becomes readable after the WB cycle ends.
   always_comb begin
      hazard = valid_D &
               ((valid_E & raw_match(use_D, use_E)) |
                (valid_M & raw_match(use_D, use_M)) |
                (valid_W & raw_match(use_D, use_W)));
   end

   // Control outputs are zero latency. Reset overrides everything; a hazard
   // freezes fetch/decode and bubbles EX while MEM and WB keep draining.
   always_comb begin
      pc_enable    = 1'b1;
      IF_ID_enable = 1'b1;
      ID_EX_enable = 1'b1;
      ID_EX_flush  = 1'b0;
      EX_ME_enable = 1'b1;
      EX_ME_flush  = 1'b0;
      ME_WB_enable = 1'b1;
      ME_WB_flush  = 1'b0;
      if (rst) begin
         pc_enable    = 1'b0;
         IF_ID_enable = 1'b0;
         ID_EX_enable = 1'b0;
         ID_EX_flush  = 1'b1;
         EX_ME_enable = 1'b0;
         EX_ME_flush  = 1'b1;
         ME_WB_enable = 1'b0;
         ME_WB_flush  = 1'b1;
      end else if (hazard) begin
         pc_enable    = 1'b0;
         IF_ID_enable = 1'b0;
         ID_EX_flush  = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_detection.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection
// Drives the hazard unit from a behavioural model of the pipeline: the model
// holds the instruction in each stage, advances it using the control values
// the rules predict, and compares the DUT controls every cycle.
// -----------------------------------------------------------------------------
module tb_hazard_detection;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] ADD5     = 32'h002182B3;  // add x5,x3,x2
   localparam logic [31:0] XOR6     = 32'h0012C333;  // xor x6,x5,x1
   localparam logic [31:0] SUB9     = 32'h405184B3;  // sub x9,x3,x5
   localparam logic [31:0] OR2      = 32'h0053E133;  // or  x2,x7,x5
   localparam logic [31:0] ADDX0    = 32'h00218033;  // add x0,x3,x2
   localparam logic [31:0] READX0   = 32'h00000333;  // add x6,x0,x0
   localparam logic [31:0] LUI7     = 32'h000283B7;  // lui x7,0x28 (field[19:15]=5)
   localparam logic [31:0] SW5      = 32'h00502023;  // sw  x5,0(x0)
   localparam logic [31:0] BEQ      = 32'h00528363;  // beq x5,x5 (field[11:7]=6)
   localparam logic [31:0] READX6   = 32'h000303B3;  // add x7,x6,x0
   localparam logic [31:0] ADD6     = 32'h00218333;  // add x6,x3,x2
   localparam logic [31:0] ADD7_56  = 32'h006283B3;  // add x7,x5,x6

   // {pc, IF_ID_en, ID_EX_en, ID_EX_fl, EX_ME_en, EX_ME_fl, ME_WB_en, ME_WB_fl}
   localparam logic [7:0] CTL_RESET = 8'b0001_0101;
   localparam logic [7:0] CTL_RUN   = 8'b1110_1010;
   localparam logic [7:0] CTL_STALL = 8'b0011_1010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_D = NOP;
   logic [31:0] instr_E = NOP;
   logic [31:0] instr_M = NOP;
   logic [31:0] instr_W = NOP;
   logic        pc_enable;
   logic        IF_ID_enable;
   logic        ID_EX_enable;
   logic        ID_EX_flush;
   logic        EX_ME_enable;
   logic        EX_ME_flush;
   logic        ME_WB_enable;
   logic        ME_WB_flush;

   int vectors     = 0;
   int miscompares = 0;
   int stallCount  = 0;

   // model pipeline state
   logic [31:0] mD = NOP, mE = NOP, mM = NOP, mW = NOP;
   bit          vD = 0, vE = 0, vM = 0, vW = 0;
   logic [31:0] fetchQ[$];
   bit          randomFetch = 0;

   hazard_detection dut (
      .clk          (clk),
      .rst          (rst),
      .instr_D      (instr_D),
      .instr_E      (instr_E),
      .instr_M      (instr_M),
      .instr_W      (instr_W),
      .pc_enable    (pc_enable),
      .IF_ID_enable (IF_ID_enable),
      .ID_EX_enable (ID_EX_enable),
      .ID_EX_flush  (ID_EX_flush),
      .EX_ME_enable (EX_ME_enable),
      .EX_ME_flush  (EX_ME_flush),
      .ME_WB_enable (ME_WB_enable),
      .ME_WB_flush  (ME_WB_flush)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dutControls();
      return {pc_enable, IF_ID_enable, ID_EX_enable, ID_EX_flush,
              EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush};
   endfunction

   // Register-usage rules by instruction class
   function automatic void usage(input logic [31:0] i, output bit r1,
                                 output bit r2, output bit w);
      r1 = 0; r2 = 0; w = 0;
      case (i[6:0])
         7'b0110011: begin r1 = 1; r2 = 1; w = 1; end
         7'b0010011, 7'b0000011, 7'b1100111: begin r1 = 1; w = 1; end
         7'b0100011, 7'b1100011: begin r1 = 1; r2 = 1; end
         7'b1101111, 7'b0110111, 7'b0010111: w = 1;
         default: ;
      endcase
      if (i[11:7] == 5'd0) w = 0;
   endfunction

   // Set of registers with a write still pending in EX/MEM/WB, checked
   // against the registers the ID instruction needs.
   function automatic bit modelHazard();
      logic [31:0] pending;
      logic [31:0] older[3];
      bit          oldValid[3];
      bit r1, r2, w;
      pending = '0;
      older = '{mE, mM, mW};
      oldValid = '{vE, vM, vW};
      for (int s = 0; s < 3; s++) begin
         usage(older[s], r1, r2, w);
         if (oldValid[s] && w) pending[older[s][11:7]] = 1'b1;
      end
      usage(mD, r1, r2, w);
      return vD && ((r1 && pending[mD[19:15]]) || (r2 && pending[mD[24:20]]));
   endfunction

   function automatic logic [31:0] randInstr();
      logic [6:0]  ops[11];
      logic [31:0] r;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
              7'b1110011};
      r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 10)];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      return r;
   endfunction

   function automatic logic [31:0] fetchNext();
      if (fetchQ.size() > 0) return fetchQ.pop_front();
      if (randomFetch) return randInstr();
      return NOP;
   endfunction

   // One pipeline cycle: drive the model's stage words, check controls at the
   // falling edge, then advance the model at the rising edge.
   task automatic runCycle(input bit rstIn, input string name);
      logic [7:0] got;
      logic [7:0] exp;
      bit hz;
      rst = rstIn;
      instr_D = mD; instr_E = mE; instr_M = mM; instr_W = mW;
      @(negedge clk);
      hz  = !rstIn && modelHazard();
      exp = rstIn ? CTL_RESET : (hz ? CTL_STALL : CTL_RUN);
      got = dutControls();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: controls=%b expected=%b (D=%h E=%h M=%h W=%h vD%0d vE%0d vM%0d vW%0d)",
                  name, got, exp, mD, mE, mM, mW, vD, vE, vM, vW);
      end
      if (!rstIn && pc_enable === 1'b0) stallCount++;
      @(posedge clk);
      if (rstIn) begin
         vD = 0; vE = 0; vM = 0; vW = 0;
      end else begin
         mW = mM; vW = vM;
         mM = mE; vM = vE;
         if (hz) begin
            mE = NOP; vE = 0;
         end else begin
            mE = mD; vE = vD;
            mD = fetchNext(); vD = 1;
         end
      end
      #1;
   endtask

   task automatic startTest();
      mD = NOP; mE = NOP; mM = NOP; mW = NOP;
      fetchQ.delete();
      randomFetch = 0;
      runCycle(1'b1, "reset_entry");
      stallCount = 0;
   endtask

   task automatic checkStalls(input string name, input int expected);
      vectors++;
      if (stallCount !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s stall cycles: observed %0d, required %0d", name, stallCount, expected);
      end
   endtask

   task automatic runProgram(input string name, input int expected);
      startTest();
      repeat (9) runCycle(1'b0, name);
      checkStalls(name, expected);
   endtask

   task automatic test_reset();
      mD = randInstr(); mE = randInstr(); mM = randInstr(); mW = randInstr();
      fetchQ.delete();
      repeat (3) runCycle(1'b1, "reset_hold");
      runCycle(1'b0, "reset_release");
   endtask

   task automatic test_adjacent();
      fetchQ.delete();
      startTest();
      fetchQ = '{ADD5, XOR6};
      repeat (9) runCycle(1'b0, "adjacent");
      checkStalls("adjacent", 3);
   endtask

   task automatic test_distance();
      startTest();
      fetchQ = '{ADD5, NOP, SUB9};
      repeat (9) runCycle(1'b0, "distance2");
      checkStalls("distance2", 2);
      startTest();
      fetchQ = '{ADD5, NOP, NOP, SUB9};
      repeat (9) runCycle(1'b0, "distance3");
      checkStalls("distance3", 1);
   endtask

   task automatic test_rs2_x0();
      startTest();
      fetchQ = '{ADD5, OR2};
      repeat (9) runCycle(1'b0, "rs2_match");
      checkStalls("rs2_match", 3);
      startTest();
      fetchQ = '{ADDX0, READX0};
      repeat (9) runCycle(1'b0, "x0_write");
      checkStalls("x0_write", 0);
   endtask

   task automatic test_non_reader_writer();
      startTest();
      fetchQ = '{ADD5, LUI7};
      repeat (9) runCycle(1'b0, "lui_reader");
      checkStalls("lui_reader", 0);
      startTest();
      fetchQ = '{ADD5, SW5};
      repeat (9) runCycle(1'b0, "store_rs2");
      checkStalls("store_rs2", 3);
      startTest();
      fetchQ = '{BEQ, READX6};
      repeat (9) runCycle(1'b0, "branch_producer");
      checkStalls("branch_producer", 0);
   endtask

   task automatic test_multi_producer();
      startTest();
      fetchQ = '{ADD5, ADD6, ADD7_56};
      repeat (10) runCycle(1'b0, "multi_producer");
      checkStalls("multi_producer", 3);
   endtask

   task automatic test_reset_during_stall();
      logic [7:0] got;
      logic [7:0] exp[3];
      startTest();
      fetchQ = '{ADD5, XOR6};
      repeat (3) runCycle(1'b0, "pre_stall");   // third cycle is stall #1
      // second stall cycle: xor in D, bubble in E, add in M
      rst = 1'b0;
      instr_D = mD; instr_E = mE; instr_M = mM; instr_W = mW;
      #2;
      got = dutControls();
      vectors++;
      if (got !== CTL_STALL) begin
         miscompares++;
         $display("[TB] FAIL stall_cycle2: controls=%b expected=%b", got, CTL_STALL);
      end
      rst = 1'b1;
      #1;
      got = dutControls();
      vectors++;
      if (got !== CTL_RESET) begin
         miscompares++;
         $display("[TB] FAIL reset_async: controls=%b expected=%b", got, CTL_RESET);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      instr_D = XOR6; instr_E = ADD5; instr_M = NOP; instr_W = NOP;
      // valid bits refill one stage per cycle; only the third cycle sees E valid
      exp = '{CTL_RUN, CTL_RUN, CTL_STALL};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         got = dutControls();
         vectors++;
         if (got !== exp[c]) begin
            miscompares++;
            $display("[TB] FAIL post_reset_cycle%0d: controls=%b expected=%b", c, got, exp[c]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random();
      startTest();
      randomFetch = 1;
      for (int n = 0; n < 800; n++) begin
         runCycle($urandom_range(0, 59) == 0, "random");
      end
      randomFetch = 0;
   endtask

   initial begin
      $display("[TB] hazard_detection bench start");
      test_reset();
      test_adjacent();
      test_distance();
      test_rs2_x0();
      test_non_reader_writer();
      test_multi_producer();
      test_reset_during_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
